serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents the registered difference and final borrow with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // One extra bit so WIDTH=1 still has a well-formed counter.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sh_reg, sh_next;
  logic [WIDTH-1:0] diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg, br_next, d_bit, last_bit;
  logic             busy_reg, done_reg, bout_reg;

  assign d_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign br_next  = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & br_reg) | (b_reg[0] & br_reg);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts bit i sits at position i.
  assign sh_next  = WIDTH'({d_bit, sh_reg} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sh_reg    <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            br_reg    <= bin;
            sh_reg    <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br_reg  <= br_next;
          sh_reg  <= sh_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            diff_reg  <= sh_next;
            bout_reg  <= br_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       s1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] last_d8 = '0;
  logic       last_b8 = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input logic [7:0] ed, input logic eb);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    a8 = ~ta; b8 = ~tb; bin8 = ~tbin;
    busy_cnt = busy8;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      busy_cnt += busy8;
      if (cyc == 4) begin
        check("hold_diff", diff8, last_d8);
        check("hold_bout", bout8, last_b8);
      end
    end
    check("latency8", cyc, 8);
    check("busy_cycles", busy_cnt, 8);
    check("diff8", diff8, ed);
    check("bout8", bout8, eb);
    $display("op8 a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d", ta, tb, tbin, diff8, bout8);
    last_d8 = ed; last_b8 = eb;
    @(posedge clk); #1;
    check("done_single", done8, 0);
  endtask

  task automatic op1(input logic ta, input logic tb, input logic tbin,
                     input logic ed, input logic eb);
    int cyc;
    @(negedge clk);
    a1 = ta; b1 = tb; bin1 = tbin; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    a1 = ~ta; b1 = ~tb; bin1 = ~tbin;
    cyc = 0;
    while (!done1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency1", cyc, 1);
    check("diff1", diff1, ed);
    check("bout1", bout1, eb);
    $display("op1 a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d", ta, tb, tbin, diff1, bout1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ta, tb, ha, hb;
    logic       tbin;
    logic [8:0] r9;
    int         done_cnt;
    logic [7:0] exp_d [3];
    logic       exp_b [3];
    // Full-subtractor truth table indexed by {a,b,bin}.
    logic [7:0] tt_d;
    logic [7:0] tt_b;
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_bout", bout8, 0);
    check("rst_busy1", busy1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    op8(8'h01, 8'hFF, 1'b0, 8'h02, 1'b1);

    // start held high with operands changing every cycle: accepts at j=0,10,20
    for (int k = 0; k < 3; k++) begin
      ha = 8'((k * 10) * 37 + 11);
      hb = 8'((k * 10) * 53 + 200);
      exp_d[k] = ha - hb;
      exp_b[k] = (ha < hb);
    end
    done_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      s8 = 1'b1;
      a8 = 8'(j * 37 + 11);
      b8 = 8'(j * 53 + 200);
      bin8 = 1'b0;
      @(posedge clk); #1;
      if (done8) done_cnt++;
      if (j % 10 == 8) begin
        check("held_done", done8, 1);
        check("held_diff", diff8, exp_d[j / 10]);
        check("held_bout", bout8, exp_b[j / 10]);
        $display("held j=%0d -> diff=%02h bout=%0d", j, diff8, bout8);
      end
    end
    @(negedge clk);
    s8 = 1'b0;
    check("held_done_count", done_cnt, 3);
    last_d8 = exp_d[2]; last_b8 = exp_b[2];
    repeat (2) @(posedge clk);

    // reset asserted during the fourth RUN cycle
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_diff", diff8, 0);
    check("mid_rst_bout", bout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) done_cnt++;
    end
    check("no_done_after_rst", done_cnt, 0);
    $display("reset mid-run -> done pulses=%0d", done_cnt);
    last_d8 = 8'h00; last_b8 = 1'b0;
    op8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ta = 8'($urandom);
      tb = 8'($urandom);
      tbin = 1'($urandom);
      r9 = {1'b0, ta} - {1'b0, tb} - {8'b0, tbin};
      op8(ta, tb, tbin, r9[7:0], r9[8]);
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      op1(idx[2], idx[1], idx[0], tt_d[i], tt_b[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
